// File: rtl/regfile_scoreboard.sv
// 32-entry register file with two combinational read ports, one write port
// and a per-register busy scoreboard (issue sets, writeback clears).
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data
// and write-side busy clearing to the read ports.

// One bit of one read port: 32:1 selection across a bit column.
module regfile_bit_mux (
    input  logic [31:0] col,
    input  logic [4:0]  sel,
    output logic        bit_out
);
    assign bit_out = col[sel];
endmodule

module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [4:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_issueEnable,
    input  logic [4:0]            ctrl_issueReg,
    input  logic [4:0]            ctrl_readRegA,
    input  logic [4:0]            ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [5:0]            busy_count
);

    localparam logic ZR = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0]       regs [32];
    logic [31:0]                 busy;
    logic [31:0]                 busy_nxt;
    logic [DATA_WIDTH-1:0][31:0] cols;
    logic [DATA_WIDTH-1:0]       sel_a;
    logic [DATA_WIDTH-1:0]       sel_b;
    logic                        wr_ok;
    logic                        iss_ok;

    // r0 swallows writes and issues when it is hardwired to zero
    assign wr_ok  = ctrl_writeEnable && !(ZR && (ctrl_writeReg == 5'd0));
    assign iss_ok = ctrl_issueEnable && !(ZR && (ctrl_issueReg == 5'd0));

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

    // Register storage: write port, cleared on reset
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int r = 0; r < 32; r++) regs[r] <= '0;
        end else if (wr_ok) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Next busy vector: write clears, then issue sets so the newer producer wins
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)  busy_nxt[ctrl_writeReg] = 1'b0;
        if (iss_ok) busy_nxt[ctrl_issueReg] = 1'b1;
        if (ZR)     busy_nxt[0] = 1'b0;
    end

    // Busy bits and their population count are updated together so they never disagree
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount32(busy_nxt);
        end
    end

    // Transpose storage into bit columns; r0 forced to zero when hardwired
    always_comb begin
        cols = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            for (int r = 0; r < 32; r++) begin
                cols[b][r] = (ZR && r == 0) ? 1'b0 : regs[r][b];
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < DATA_WIDTH; gb++) begin : g_bit
            regfile_bit_mux u_mux_a (.col(cols[gb]), .sel(ctrl_readRegA), .bit_out(sel_a[gb]));
            regfile_bit_mux u_mux_b (.col(cols[gb]), .sel(ctrl_readRegB), .bit_out(sel_b[gb]));
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;
    assign fwd_a = wr_ok && (ctrl_readRegA == ctrl_writeReg);
    assign fwd_b = wr_ok && (ctrl_readRegB == ctrl_writeReg);

    // Forward in-flight write data; a same-cycle issue to the register keeps its stored busy
    always_comb begin
        data_readRegA = fwd_a ? data_writeReg : sel_a;
        data_readRegB = fwd_b ? data_writeReg : sel_b;
        busy_readRegA = busy[ctrl_readRegA];
        busy_readRegB = busy[ctrl_readRegB];
        if (fwd_a && !(iss_ok && ctrl_issueReg == ctrl_readRegA)) busy_readRegA = 1'b0;
        if (fwd_b && !(iss_ok && ctrl_issueReg == ctrl_readRegB)) busy_readRegB = 1'b0;
    end
`else
    // Stored state only; a write becomes visible after its edge
    always_comb begin
        data_readRegA = sel_a;
        data_readRegB = sel_b;
        busy_readRegA = busy[ctrl_readRegA];
        busy_readRegB = busy[ctrl_readRegB];
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (ZERO_REG=1, 32-bit data).
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busy_readRegA;
    logic        busy_readRegB;
    logic [5:0]  busy_count;

    regfile_scoreboard #(.DATA_WIDTH(32), .ZERO_REG(1)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .busy_readRegA(busy_readRegA), .busy_readRegB(busy_readRegB),
        .busy_count(busy_count)
    );

    always #5 clock = ~clock;

    // kind: 0 dataA, 1 dataB, 2 busyA, 3 busyB, 4 busy_count
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_v(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge, then apply inputs
    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ir,
                        input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clock); #1;
        ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
        ctrl_issueEnable = ie; ctrl_issueReg = ir;
        ctrl_readRegA = ra; ctrl_readRegB = rb;
    endtask

    // Monitor: outputs are stable at the falling edge; drain every queued expectation
    initial begin
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    0: act = data_readRegA;
                    1: act = data_readRegB;
                    2: act = {31'd0, busy_readRegA};
                    3: act = {31'd0, busy_readRegB};
                    default: act = {26'd0, busy_count};
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_issueEnable = 1'b0; ctrl_issueReg = '0;
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd6;
        expect_v("rst_dataA", 0, 32'h0);
        expect_v("rst_busyA", 2, 32'h0);
        expect_v("rst_count", 4, 32'h0);
        @(posedge clock); #1; ctrl_reset = 1'b0;

        // Reset mid-operation clears state asynchronously
        step(1, 5'd5, 32'hDEADBEEF, 1, 5'd6, 5'd5, 5'd6);
        step(0, 0, 0, 0, 0, 5'd5, 5'd6);
        expect_v("t1_pre_dataA", 0, 32'hDEADBEEF);
        expect_v("t1_pre_busyB", 3, 32'h1);
        expect_v("t1_pre_count", 4, 32'h1);
        @(posedge clock); #2; ctrl_reset = 1'b1; #1;
        expect_v("t1_async_dataA", 0, 32'h0);
        expect_v("t1_async_busyB", 3, 32'h0);
        expect_v("t1_async_count", 4, 32'h0);
        @(posedge clock); #1; ctrl_reset = 1'b0;

        // Write then read on both ports
        step(1, 5'd7, 32'h12345678, 0, 0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd7, 5'd7);
        expect_v("t2_dataA", 0, 32'h12345678);
        expect_v("t2_dataB", 1, 32'h12345678);
        expect_v("t2_busyA", 2, 32'h0);
        expect_v("t2_busyB", 3, 32'h0);

        // Scoreboard set/clear
        step(0, 0, 0, 1, 5'd3, 5'd3, 5'd4);
        step(0, 0, 0, 1, 5'd4, 5'd3, 5'd4);
        expect_v("t3_count1", 4, 32'd1);
        expect_v("t3_busyA3", 2, 32'h1);
        expect_v("t3_busyB4", 3, 32'h0);
        step(1, 5'd3, 32'h00000033, 0, 0, 5'd3, 5'd4);
        expect_v("t3_count2", 4, 32'd2);
        expect_v("t3_busyB4b", 3, 32'h1);
        step(0, 0, 0, 0, 0, 5'd3, 5'd4);
        expect_v("t3_count_after_wb", 4, 32'd1);
        expect_v("t3_busyA3_clr", 2, 32'h0);
        expect_v("t3_dataA3", 0, 32'h00000033);

        // Same-edge write + issue to r9: data lands, busy stays set
        step(1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 5'd9, 5'd9);
        step(0, 0, 0, 0, 0, 5'd9, 5'd9);
        expect_v("t4_dataA9", 0, 32'hA5A5A5A5);
        expect_v("t4_busyA9", 2, 32'h1);
        expect_v("t4_busyB9", 3, 32'h1);
        expect_v("t4_count", 4, 32'd2);

        // Re-issue busy r4 and write non-busy r10: count unchanged
        step(1, 5'd10, 32'h0000AAAA, 1, 5'd4, 5'd4, 5'd10);
        step(0, 0, 0, 0, 0, 5'd4, 5'd10);
        expect_v("t4b_busyA4", 2, 32'h1);
        expect_v("t4b_busyB10", 3, 32'h0);
        expect_v("t4b_dataB10", 1, 32'h0000AAAA);
        expect_v("t4b_count", 4, 32'd2);

        // Hardwired r0 ignores write and issue
        step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0, 5'd0);
        expect_v("t5_dataA0", 0, 32'h0);
        expect_v("t5_busyA0", 2, 32'h0);
        expect_v("t5_count", 4, 32'd2);

        // Same-cycle read of register being written
        step(1, 5'd12, 32'h0BADF00D, 0, 0, 5'd12, 5'd9);
`ifdef REGFILE_BYPASS_EN
        expect_v("t6_bypass_dataA", 0, 32'h0BADF00D);
`else
        expect_v("t6_nobypass_dataA", 0, 32'h0);
`endif
        expect_v("t6_busyA", 2, 32'h0);
        step(0, 0, 0, 0, 0, 5'd12, 5'd12);
        expect_v("t6_next_dataA", 0, 32'h0BADF00D);

        // Fill the scoreboard: r1..r31 busy, count saturates at 31 with r0 hardwired
        for (int r = 1; r < 32; r++) step(0, 0, 0, 1, 5'(r), 5'd31, 5'd1);
        step(0, 0, 0, 1, 5'd31, 5'd31, 5'd1);
        expect_v("t7_count_full", 4, 32'd31);
        expect_v("t7_busyA31", 2, 32'h1);
        step(0, 0, 0, 0, 0, 5'd31, 5'd1);
        expect_v("t7_count_reissue", 4, 32'd31);
        step(1, 5'd31, 32'h1, 0, 0, 5'd31, 5'd1);
        step(0, 0, 0, 0, 0, 5'd31, 5'd1);
        expect_v("t7_count_wb", 4, 32'd30);
        expect_v("t7_busyA31_clr", 2, 32'h0);

        // Bounded drain of remaining expectations
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
